// File: rtl/adam_aes_sbox_arbiter_if.sv
// Request/grant/response bundle between AES requesters (master) and the shared S-box arbiter (slave).
// Requester i owns bit i of the per-requester vectors and bits [32*i+31:32*i] of req_word.
interface adam_aes_sbox_arbiter_if #(
   parameter int NUM_REQ = 2
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [32*NUM_REQ-1:0] req_word;
   logic [NUM_REQ-1:0]    req_lock;
   logic [NUM_REQ-1:0]    gnt;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic [31:0]           rsp_word;

   modport master (
      output req_valid, req_word, req_lock,
      input  gnt, rsp_valid, rsp_word
   );

   modport slave (
      input  req_valid, req_word, req_lock,
      output gnt, rsp_valid, rsp_word
   );
endinterface

// File: rtl/adam_aes_sbox_arbiter.sv
// Round-robin arbiter sharing one 32-bit S-box among NUM_REQ (2..4) AES requesters.
// Define SBOX_ARB_LOCK_EN to add the 4-word burst lock driven by req_lock.
module adam_aes_sbox_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   adam_aes_sbox_arbiter_if.slave bus,
   output logic [31:0]           sbox_w,
   input  logic [31:0]           sbox_new_w,
   output logic                  busy
);
   localparam int RW = 2;

   logic [RW-1:0]      rr_ptr_reg;
   logic [RW-1:0]      rr_ptr_next;
   logic [NUM_REQ-1:0] rsp_valid_reg;
   logic [31:0]        rsp_word_reg;
   logic [NUM_REQ-1:0] elig;
   logic [3:0]         elig_ext;
   logic               found;
   logic [RW-1:0]      win;
   logic [2:0]         idx;
   logic [2:0]         win_inc;
   logic               accept;
   logic               locked;
   logic [31:0]        words [4];

   // Pad the word table to four entries so the mux never indexes past req_word.
   for (genvar gi = 0; gi < 4; gi++) begin : g_words
      if (gi < NUM_REQ) begin : g_real
         assign words[gi] = bus.req_word[32*gi +: 32];
      end else begin : g_pad
         assign words[gi] = 32'h0;
      end
   end

`ifdef SBOX_ARB_LOCK_EN
   localparam logic [0:0] ST_UNLOCKED = 1'b0;
   localparam logic [0:0] ST_LOCKED   = 1'b1;

   logic [0:0]    state_reg, state_next;
   logic [RW-1:0] owner_reg, owner_next;
   logic [1:0]    burst_ctr_reg, burst_ctr_next;
   logic [3:0]    lock_ext;
   logic [3:0]    owner_mask;

   assign lock_ext   = 4'(bus.req_lock);
   assign owner_mask = 4'b0001 << owner_reg;
   assign locked     = (state_reg == ST_LOCKED);
   assign elig       = locked ? (bus.req_valid & owner_mask[NUM_REQ-1:0]) : bus.req_valid;

   always_comb begin
      state_next     = state_reg;
      owner_next     = owner_reg;
      burst_ctr_next = burst_ctr_reg;
      case (state_reg)
         ST_UNLOCKED: begin
            if (accept && lock_ext[win]) begin
               state_next     = ST_LOCKED;
               owner_next     = win;
               burst_ctr_next = 2'd1;
            end
         end
         default: begin
            // While locked only the owner can win, so any accept is an owner grant.
            if (accept) begin
               if (burst_ctr_reg == 2'd3) begin
                  state_next     = ST_UNLOCKED;
                  burst_ctr_next = 2'd0;
               end else begin
                  burst_ctr_next = burst_ctr_reg + 2'd1;
               end
            end else if (!lock_ext[owner_reg]) begin
               state_next     = ST_UNLOCKED;
               burst_ctr_next = 2'd0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= ST_UNLOCKED;
         owner_reg     <= '0;
         burst_ctr_reg <= 2'd0;
      end else begin
         state_reg     <= state_next;
         owner_reg     <= owner_next;
         burst_ctr_reg <= burst_ctr_next;
      end
   end
`else
   logic unused_lock;

   assign unused_lock = ^bus.req_lock;
   assign locked      = 1'b0;
   assign elig        = bus.req_valid;
`endif

   assign elig_ext = 4'(elig);

   // First eligible requester at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = 3'(rr_ptr_reg) + 3'(k);
         if (idx >= 3'(NUM_REQ)) idx = idx - 3'(NUM_REQ);
         if (!found && elig_ext[idx[1:0]]) begin
            found = 1'b1;
            win   = idx[1:0];
         end
      end
   end

   assign accept      = found && reset_n;
   assign win_inc     = 3'(win) + 3'd1;
   assign rr_ptr_next = (win_inc == 3'(NUM_REQ)) ? '0 : win_inc[RW-1:0];
   assign sbox_w      = found ? words[win] : 32'h0;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
      assign bus.gnt[gi] = accept && (win == RW'(gi));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr_reg    <= '0;
         rsp_valid_reg <= '0;
         rsp_word_reg  <= 32'h0;
      end else begin
         rsp_valid_reg <= bus.gnt;
         if (accept) begin
            rsp_word_reg <= sbox_new_w;
            rr_ptr_reg   <= rr_ptr_next;
         end
      end
   end

   assign bus.rsp_valid = rsp_valid_reg;
   assign bus.rsp_word  = rsp_word_reg;
   assign busy          = (|bus.req_valid) || (|rsp_valid_reg) || locked;
endmodule

// File: tb/tb_adam_aes_sbox_arbiter.sv
// Directed bench for adam_aes_sbox_arbiter (NUM_REQ = 2) with a behavioural AES S-box on sbox_w.
// Lock-scenario expectations follow whether SBOX_ARB_LOCK_EN is defined.
module tb_adam_aes_sbox_arbiter;
   logic        clk;
   logic        reset_n;
   logic [31:0] sbox_w;
   logic [31:0] sbox_new_w;
   logic        busy;
   int          checks;
   int          errors;

   adam_aes_sbox_arbiter_if #(.NUM_REQ(2)) bus ();

   adam_aes_sbox_arbiter #(.NUM_REQ(2)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (bus),
      .sbox_w     (sbox_w),
      .sbox_new_w (sbox_new_w),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = xtime(a);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] sbyte(input logic [7:0] a);
      logic [7:0] r = 8'h01;
      for (int i = 0; i < 254; i++) r = gmul(r, a);
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   assign sbox_new_w = {sbyte(sbox_w[31:24]), sbyte(sbox_w[23:16]),
                        sbyte(sbox_w[15:8]),  sbyte(sbox_w[7:0])};

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      bus.req_valid = 2'b00;
      bus.req_word  = 64'h0;
      bus.req_lock  = 2'b00;
   endtask

   task automatic do_reset;
      idle_inputs();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset;
      idle_inputs();
      reset_n = 1'b0;
      #1;
      bus.req_valid = 2'b11;
      #1;
      checks++;
      if (bus.gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", bus.gnt); end
      bus.req_valid = 2'b00;
      tick();
      checks++;
      if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 00", bus.rsp_valid); end
      checks++;
      if (bus.rsp_word !== 32'h0) begin errors++; $display("FAIL reset_rsp_word: got %h expected 00000000", bus.rsp_word); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      reset_n = 1'b1;
      $display("test_reset done");
   endtask

   task automatic test_single;
      do_reset();
      bus.req_valid = 2'b01;
      bus.req_word  = 64'h0;
      #1;
      checks++;
      if (bus.gnt !== 2'b01) begin errors++; $display("FAIL single_gnt: got %b expected 01", bus.gnt); end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
      tick();
      bus.req_valid = 2'b00;
      #1;
      checks++;
      if (bus.rsp_valid !== 2'b01) begin errors++; $display("FAIL single_rsp_valid: got %b expected 01", bus.rsp_valid); end
      checks++;
      if (bus.rsp_word !== 32'h63636363) begin errors++; $display("FAIL single_rsp_word: got %h expected 63636363", bus.rsp_word); end
      checks++;
      if (bus.gnt !== 2'b00) begin errors++; $display("FAIL single_idle_gnt: got %b expected 00", bus.gnt); end
      tick();
      checks++;
      if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL single_rsp_drop: got %b expected 00", bus.rsp_valid); end
      checks++;
      if (bus.rsp_word !== 32'h63636363) begin errors++; $display("FAIL single_rsp_hold: got %h expected 63636363", bus.rsp_word); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle: got %b expected 0", busy); end
      $display("test_single done");
   endtask

   task automatic test_round_robin;
      logic [1:0]  eg [0:5];
      logic [31:0] ew [0:5];
      logic [31:0] es [0:5];
      eg = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
      ew = '{32'hEDEDEDED, 32'h7C777BF2, 32'hEDEDEDED, 32'h7C777BF2, 32'hEDEDEDED, 32'h7C777BF2};
      es = '{32'h53535353, 32'h01020304, 32'h53535353, 32'h01020304, 32'h53535353, 32'h01020304};
      do_reset();
      bus.req_valid = 2'b11;
      bus.req_word  = {32'h01020304, 32'h53535353};
      for (int c = 0; c < 7; c++) begin
         if (c == 6) bus.req_valid = 2'b00;
         #1;
         if (c > 0) begin
            checks++;
            if (bus.rsp_valid !== eg[c-1]) begin errors++; $display("FAIL rr_rsp_valid cycle %0d: got %b expected %b", c, bus.rsp_valid, eg[c-1]); end
            checks++;
            if (bus.rsp_word !== ew[c-1]) begin errors++; $display("FAIL rr_rsp_word cycle %0d: got %h expected %h", c, bus.rsp_word, ew[c-1]); end
         end
         if (c < 6) begin
            checks++;
            if (bus.gnt !== eg[c]) begin errors++; $display("FAIL rr_gnt cycle %0d: got %b expected %b", c, bus.gnt, eg[c]); end
            checks++;
            if (sbox_w !== es[c]) begin errors++; $display("FAIL rr_sbox_w cycle %0d: got %h expected %h", c, sbox_w, es[c]); end
         end
         tick();
      end
      $display("test_round_robin done");
   endtask

   task automatic test_work_conserving;
      do_reset();
      bus.req_valid = 2'b10;
      bus.req_word  = {32'h01020304, 32'h00000000};
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (bus.gnt !== 2'b10) begin errors++; $display("FAIL wc_gnt cycle %0d: got %b expected 10", c, bus.gnt); end
         if (c > 0) begin
            checks++;
            if (bus.rsp_word !== 32'h7C777BF2) begin errors++; $display("FAIL wc_rsp_word cycle %0d: got %h expected 7c777bf2", c, bus.rsp_word); end
         end
         tick();
      end
      bus.req_valid = 2'b11;
      #1;
      checks++;
      if (bus.gnt !== 2'b01) begin errors++; $display("FAIL wc_req0_gnt: got %b expected 01", bus.gnt); end
      checks++;
      if (bus.rsp_valid !== 2'b10) begin errors++; $display("FAIL wc_rsp_valid: got %b expected 10", bus.rsp_valid); end
      tick();
      bus.req_valid = 2'b00;
      #1;
      checks++;
      if (bus.rsp_word !== 32'h63636363) begin errors++; $display("FAIL wc_req0_rsp: got %h expected 63636363", bus.rsp_word); end
      tick();
      $display("test_work_conserving done");
   endtask

   task automatic test_reset_mid;
      do_reset();
      bus.req_valid = 2'b11;
      bus.req_word  = {32'h01020304, 32'h53535353};
      tick();
      #1;
      checks++;
      if (bus.rsp_word !== 32'hEDEDEDED) begin errors++; $display("FAIL rm_pre_rsp: got %h expected ededeDED", bus.rsp_word); end
      reset_n = 1'b0;
      #1;
      checks++;
      if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL rm_async_rsp_valid: got %b expected 00", bus.rsp_valid); end
      checks++;
      if (bus.rsp_word !== 32'h0) begin errors++; $display("FAIL rm_async_rsp_word: got %h expected 00000000", bus.rsp_word); end
      checks++;
      if (bus.gnt !== 2'b00) begin errors++; $display("FAIL rm_gnt: got %b expected 00", bus.gnt); end
      tick();
      checks++;
      if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL rm_rsp_stays: got %b expected 00", bus.rsp_valid); end
      reset_n = 1'b1;
      #1;
      checks++;
      if (bus.gnt !== 2'b01) begin errors++; $display("FAIL rm_first_gnt: got %b expected 01", bus.gnt); end
      tick();
      checks++;
      if (bus.rsp_word !== 32'hEDEDEDED) begin errors++; $display("FAIL rm_post_rsp: got %h expected ededeDED", bus.rsp_word); end
      idle_inputs();
      tick();
      $display("test_reset_mid done");
   endtask

   task automatic test_lock_burst;
      logic [1:0] eg [0:4];
`ifdef SBOX_ARB_LOCK_EN
      eg = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
`else
      eg = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`endif
      do_reset();
      bus.req_valid = 2'b01;
      bus.req_word  = {32'h01020304, 32'h53535353};
      tick();
      bus.req_valid = 2'b11;
      bus.req_lock  = 2'b10;
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++;
         if (bus.gnt !== eg[c]) begin errors++; $display("FAIL lock_burst_gnt cycle %0d: got %b expected %b", c, bus.gnt, eg[c]); end
         tick();
      end
      idle_inputs();
      tick();
      tick();
      $display("test_lock_burst done");
   endtask

   task automatic test_lock_release;
      logic [1:0] eg [0:3];
`ifdef SBOX_ARB_LOCK_EN
      eg = '{2'b10, 2'b10, 2'b00, 2'b01};
`else
      eg = '{2'b10, 2'b01, 2'b01, 2'b01};
`endif
      do_reset();
      bus.req_valid = 2'b01;
      bus.req_word  = {32'h01020304, 32'h53535353};
      tick();
      bus.req_valid = 2'b11;
      bus.req_lock  = 2'b10;
      for (int c = 0; c < 4; c++) begin
         if (c == 2) begin
            bus.req_valid = 2'b01;
            bus.req_lock  = 2'b00;
         end
         #1;
         checks++;
         if (bus.gnt !== eg[c]) begin errors++; $display("FAIL lock_rel_gnt cycle %0d: got %b expected %b", c, bus.gnt, eg[c]); end
         if (c == 2) begin
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL lock_rel_busy: got %b expected 1", busy); end
         end
         tick();
      end
      idle_inputs();
      tick();
      $display("test_lock_release done");
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      reset_n = 1'b0;
      idle_inputs();
      tick();
      test_reset();
      test_single();
      test_round_robin();
      test_work_conserving();
      test_reset_mid();
      test_lock_burst();
      test_lock_release();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/adam_aes_sbox_arbiter.md
Name: adam_aes_sbox_arbiter

Overview:
- Shares one combinational 32-bit S-box (four byte S-boxes) between several AES requesters, e.g. requester 0 = key memory (key expansion), requester 1 = encipher block (SubBytes, one word per cycle).
- Round-robin arbitration with a request/grant handshake and a registered per-requester response.
- Sits in the AES core between the requesters and the shared S-box instance.

Parameters:
- NUM_REQ, 2, number of requesters (2..4); index width RW = 2 bits.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester substitution request
- req_word  in  32*NUM_REQ  word to substitute; requester i occupies bits [32*i+31:32*i]
- req_lock  in  NUM_REQ  burst-lock request; used only with SBOX_ARB_LOCK_EN
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as accept
- rsp_valid  out  NUM_REQ  one-hot, registered; 1-cycle pulse carrying the result
- rsp_word  out  32  substituted word for the requester flagged in rsp_valid
- sbox_w  out  32  word driven to the shared S-box
- sbox_new_w  in  32  S-box result (combinational from sbox_w)
- busy  out  1  OR of req_valid, rsp_valid and lock state

Behaviour:
- Reset values (asynchronous):
  - rsp_valid = 0, rsp_word = 0.
  - Internal: rr_ptr = 0, lock state = UNLOCKED, burst_ctr = 0.
  - gnt is 0 while reset_n = 0.
- Arbitration, each cycle:
  - Search req_valid starting at index rr_ptr, ascending, wrapping modulo NUM_REQ. The first set bit is the winner.
  - gnt[winner] = 1 and sbox_w = req_word[winner].
  - If no request: gnt = 0 and sbox_w = 0.
- Accept:
  - At the clock edge where gnt[i] = 1: rsp_valid <= one-hot(i), rsp_word <= sbox_new_w, rr_ptr <= (i+1) mod NUM_REQ.
  - Latency is exactly 1 cycle from grant to response.
- No accept in a cycle: rsp_valid <= 0; rsp_word holds its value; rr_ptr holds.
- Handshake:
  - A requester holds req_valid and req_word stable until it sees gnt.
  - It may present its next word in the cycle after gnt, giving throughput of 1 word/cycle per winner.
  - Dropping req_valid before grant is legal (request withdrawn). No response is produced.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0. The maximum wait is NUM_REQ-1 cycles.
- Simultaneous events: a new grant and the previous response occur in the same cycle. rsp_word always reflects the most recent grant only.
- Reset mid-operation: a pending response is discarded, rr_ptr returns to 0, and the lock is released.

Optional Feature:
- SBOX_ARB_LOCK_EN defined:
  - Adds states UNLOCKED and LOCKED, a lock owner register, and a 2-bit burst_ctr.
  - In UNLOCKED, a grant to i with req_lock[i] = 1 sets owner = i, burst_ctr = 1 and moves to LOCKED.
  - In LOCKED:
    - Only the owner may be granted; other requests wait with gnt = 0.
    - Each owner grant increments burst_ctr.
    - The 4th grant (burst_ctr == 3 at the accept edge) returns to UNLOCKED, with rr_ptr = (owner+1) mod NUM_REQ.
    - Idle owner cycles keep the lock.
    - req_lock[owner] = 0 in any LOCKED cycle with no owner grant releases the lock immediately (back to UNLOCKED next cycle, rr_ptr unchanged).
  - Purpose: keeps the encipher block's 4-word SubBytes burst contiguous.
- SBOX_ARB_LOCK_EN undefined:
  - req_lock is ignored and no lock state exists.
  - Arbitration is pure per-word round-robin.

Test Plan:
- Reset, then req_valid = 01, req_word0 = 0x00000000 -> gnt = 01 that cycle; next cycle rsp_valid = 01, rsp_word = 0x63636363.
- Both valid continuously for 6 cycles, words 0x53535353 (req0) and 0x01020304 (req1) -> gnt sequence 01,10,01,10,01,10. Responses alternate 0xEDEDEDED and 0x7C777BF2.
- After a grant to 1, only req 1 valid for 3 cycles -> three consecutive grants to 1 (work-conserving). Then req 0 is raised -> granted within 1 cycle.
- Assert reset_n = 0 in the cycle after a grant -> rsp_valid stays 0, rsp_word = 0. The first grant after release goes to requester 0 when both are valid.
- With SBOX_ARB_LOCK_EN, req1 sets req_lock and valid for 4 words while req0 stays valid -> gnt = 10 x4, then 01. Without the macro -> alternating grants.
- With SBOX_ARB_LOCK_EN, owner 1 drops req_valid and req_lock after 2 words -> lock released, req0 granted on the following cycle.
